qsys_serial_arbiter: RTL

QSYS_SERIAL_ARBITER -- requirements
Module: qsys_serial_arbiter

---
 rtl/qsys_serial_pkg.sv | 6 +
 rtl/qsys_rr_select.sv | 33 +++
 rtl/qsys_serial_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/qsys_serial_pkg.sv
// qsys_serial_pkg: shared FSM encoding, grant index width and timeout read-return pattern
package qsys_serial_pkg;
    localparam int GRANT_W = 3;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, COMPLETE} state_t;
endpackage

// File: rtl/qsys_rr_select.sv
// qsys_rr_select: combinational round-robin pick of the first requester at or after ptr
// Ports: req (request vector), ptr (search start), grant (one-hot), idx (granted index), valid (any request)
module qsys_rr_select
    import qsys_serial_pkg::*;
#(
    parameter int NUM_REQ = 4
)(
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [GRANT_W-1:0] idx,
    output logic               valid
);
    logic [7:0]         req_pad;
    logic [GRANT_W-1:0] c;

    assign req_pad = 8'(req);

    // Walk the search window backwards so the candidate nearest ptr is written last and wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        c     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            c = GRANT_W'((int'(ptr) + k) % NUM_REQ);
            if (req_pad[c]) begin
                idx   = c;
                valid = 1'b1;
            end
        end
        grant = valid ? NUM_REQ'(1) << idx : '0;
    end
endmodule

// File: rtl/qsys_serial_arbiter.sv
// qsys_serial_arbiter: round-robin arbiter sharing one serial-device Avalon master among NUM_REQ slaves
// Ports: csi_MCLK_clk/rsi_MRST_reset clock and async reset; avs_req_* per-requester slave side;
//        avm_ser_* downstream master side; grant_id owning requester; busy not-IDLE; timeout_err sticky watchdog.
// Build option: SERIAL_ARB_TIMEOUT_EN enables the TIMEOUT_CYCLES watchdog; otherwise it waits indefinitely.
module qsys_serial_arbiter
    import qsys_serial_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 1024
)(
    input  logic                      csi_MCLK_clk,
    input  logic                      rsi_MRST_reset,
    input  logic [NUM_REQ-1:0]        avs_req_write,
    input  logic [NUM_REQ-1:0]        avs_req_read,
    input  logic [NUM_REQ*ADDR_W-1:0] avs_req_address,
    input  logic [NUM_REQ*32-1:0]     avs_req_writedata,
    output logic [NUM_REQ-1:0]        avs_req_waitrequest,
    output logic [NUM_REQ-1:0]        avs_req_readdatavalid,
    output logic [31:0]               avs_req_readdata,
    output logic                      avm_ser_chipselect,
    output logic                      avm_ser_write,
    output logic                      avm_ser_read,
    output logic [ADDR_W-1:0]         avm_ser_address,
    output logic [31:0]               avm_ser_writedata,
    input  logic                      avm_ser_waitrequest,
    input  logic                      avm_ser_readdatavalid,
    input  logic [31:0]               avm_ser_readdata,
    output logic [GRANT_W-1:0]        grant_id,
    output logic                      busy,
    output logic                      timeout_err
);
    state_t             state, state_nxt;
    logic [GRANT_W-1:0] ptr, sel_idx;
    logic [NUM_REQ-1:0] req, sel_grant, gnt_mask;
    logic               sel_valid, sel_wr, is_wr, to_fire;
    logic [ADDR_W-1:0]  addr_q, sel_addr;
    logic [31:0]        wdata_q, sel_wdata, rdata_q;

    assign req = avs_req_read | avs_req_write;

    qsys_rr_select #(.NUM_REQ(NUM_REQ)) u_sel (
        .req   (req),
        .ptr   (ptr),
        .grant (sel_grant),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    // Write wins when a requester raises read and write together.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            if (sel_grant[i]) begin
                sel_addr  = avs_req_address[i*ADDR_W +: ADDR_W];
                sel_wdata = avs_req_writedata[i*32 +: 32];
                sel_wr    = avs_req_write[i];
            end
    end

`ifdef SERIAL_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;
    logic             in_xfer, to_err_q;

    assign in_xfer = state == ISSUE || state == BUSY;
    // A device that finishes on the very last cycle still completes normally.
    assign to_fire = in_xfer && to_cnt == CNT_W'(TIMEOUT_CYCLES - 1) && (state == ISSUE || avm_ser_waitrequest);
    assign timeout_err = to_err_q;

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset)
        if (rsi_MRST_reset) begin
            to_cnt   <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_cnt   <= in_xfer ? to_cnt + CNT_W'(1) : '0;
            to_err_q <= to_err_q | to_fire;
        end
`else
    assign to_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nxt = IDLE;
        unique case (state)
            IDLE:     state_nxt = sel_valid ? ISSUE : IDLE;
            ISSUE:    state_nxt = to_fire ? COMPLETE : avm_ser_waitrequest ? BUSY : ISSUE;
            BUSY:     state_nxt = (to_fire || !avm_ser_waitrequest) ? COMPLETE : BUSY;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset)
        if (rsi_MRST_reset) begin
            state    <= IDLE;
            ptr      <= '0;
            grant_id <= '0;
            is_wr    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && sel_valid) begin
                grant_id <= sel_idx;
                is_wr    <= sel_wr;
                addr_q   <= sel_addr;
                wdata_q  <= sel_wdata;
            end
            if (state == BUSY && avm_ser_readdatavalid)
                rdata_q <= avm_ser_readdata;
            if (to_fire)
                rdata_q <= TIMEOUT_RDATA;
            if (state == COMPLETE)
                ptr <= (grant_id == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_id + GRANT_W'(1);
        end

    assign avm_ser_chipselect    = state == ISSUE;
    assign avm_ser_write         = avm_ser_chipselect && is_wr;
    assign avm_ser_read          = avm_ser_chipselect && !is_wr;
    assign avm_ser_address       = avm_ser_chipselect ? addr_q : '0;
    assign avm_ser_writedata     = avm_ser_chipselect ? wdata_q : '0;
    assign gnt_mask              = (state == COMPLETE) ? NUM_REQ'(1) << grant_id : '0;
    assign avs_req_waitrequest   = req & ~gnt_mask;
    assign avs_req_readdatavalid = is_wr ? '0 : gnt_mask;
    assign avs_req_readdata      = (state == COMPLETE && !is_wr) ? rdata_q : '0;
    assign busy                  = state != IDLE;
endmodule
